conv_out_wr_seq: RTL and testbench

//  Row sequencer directly upstream of dram_wr, in the user clock domain.

---
 rtl/conv_out_wr_seq.sv | 168 ++++++++++++++++
 tb/tb_conv_out_wr_seq.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_out_wr_seq.sv
// Row sequencer feeding dram_wr: splits the conv output stream into rows, one dram_wr transfer per row.
// Optional watchdog in WAIT_DONE is enabled by defining CONV_WR_TIMEOUT_EN.
module conv_out_wr_seq #(
  parameter int ADDR_WIDTH  = 15,
  parameter int SIZE_WIDTH  = 17,
  parameter int DATA_WIDTH  = 16,
  parameter int ROW_WIDTH   = 10,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
  input  logic [SIZE_WIDTH-1:0] cfg_row_len,
  input  logic [ROW_WIDTH-1:0]  cfg_num_rows,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic                  wr_go,
  output logic [ADDR_WIDTH-1:0] wr_start_addr,
  output logic [SIZE_WIDTH-1:0] wr_size,
  output logic                  wr_en,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_ready,
  input  logic                  wr_done,
  output logic                  busy,
  output logic                  done,
  output logic [ROW_WIDTH-1:0]  rows_done,
  output logic                  err,
  output logic [2:0]            dbg_state
);

  // Stream handshake: an element moves when s_valid & s_ready in the same cycle;
  // s_ready is only ever high in STREAM while dram_wr is ready and the row is not yet full.
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_ARM       = 3'd2,
    S_STREAM    = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FIN       = 3'd5
  } state_t;

  localparam logic [SIZE_WIDTH-1:0] SIZE_ONE = SIZE_WIDTH'(1);
  localparam logic [ROW_WIDTH-1:0]  ROW_ONE  = ROW_WIDTH'(1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [ROW_WIDTH-1:0]  num_rows_q;
  logic [ROW_WIDTH-1:0]  row;
  logic [SIZE_WIDTH-1:0] beats_left;
  logic                  done_q;
  logic                  row_end;
  logic [ADDR_WIDTH-1:0] next_addr;

`ifdef CONV_WR_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYC - 1);
  logic [15:0] wd_cnt;
`else
  assign err = 1'b0;
`endif

  assign s_ready   = (state == S_STREAM) && wr_ready && (beats_left != '0);
  assign wr_en     = s_valid && s_ready;
  assign wr_data   = (state == S_STREAM) ? s_data : '0;
  assign dbg_state = state;
  // done level from dram_wr persists across rows, so only its rising edge ends a row
  assign row_end   = wr_done && !done_q;
  assign next_addr = addr + stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      addr          <= '0;
      stride_q      <= '0;
      num_rows_q    <= '0;
      row           <= '0;
      beats_left    <= '0;
      done_q        <= 1'b0;
      wr_go         <= 1'b0;
      wr_start_addr <= '0;
      wr_size       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      rows_done     <= '0;
`ifdef CONV_WR_TIMEOUT_EN
      err           <= 1'b0;
      wd_cnt        <= '0;
`endif
    end else begin
      done_q <= wr_done;
      wr_go  <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            row        <= '0;
            rows_done  <= '0;
            addr       <= cfg_base_addr;
            stride_q   <= cfg_stride;
            num_rows_q <= cfg_num_rows;
            wr_size    <= cfg_row_len;
`ifdef CONV_WR_TIMEOUT_EN
            err        <= 1'b0;
`endif
            if (cfg_row_len == '0 || cfg_num_rows == '0) begin
              state <= S_FIN;
            end else begin
              wr_go         <= 1'b1;
              wr_start_addr <= cfg_base_addr;
              state         <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          beats_left <= wr_size;
          state      <= S_ARM;
        end
        S_ARM: begin
          state <= S_STREAM;
        end
        S_STREAM: begin
`ifdef CONV_WR_TIMEOUT_EN
          wd_cnt <= '0;
`endif
          if (wr_en) begin
            beats_left <= beats_left - SIZE_ONE;
            if (beats_left == SIZE_ONE) state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (row_end) begin
            rows_done <= rows_done + ROW_ONE;
            row       <= row + ROW_ONE;
            addr      <= next_addr;
            if (row + ROW_ONE == num_rows_q) begin
              state <= S_FIN;
            end else begin
              wr_go         <= 1'b1;
              wr_start_addr <= next_addr;
              state         <= S_ISSUE;
            end
          end
`ifdef CONV_WR_TIMEOUT_EN
          else if (wd_cnt == WD_LAST) begin
            err   <= 1'b1;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
          end
`endif
        end
        S_FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_out_wr_seq.sv
// Bench for conv_out_wr_seq: random pipeline source, behavioural dram_wr model, element/address scoreboard.
module tb_conv_out_wr_seq;
  localparam int AW = 15;
  localparam int SW = 17;
  localparam int DW = 16;
  localparam int RW = 10;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] cfg_base_addr;
  logic [AW-1:0] cfg_stride;
  logic [SW-1:0] cfg_row_len;
  logic [RW-1:0] cfg_num_rows;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic          wr_go;
  logic [AW-1:0] wr_start_addr;
  logic [SW-1:0] wr_size;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          wr_done;
  logic          busy;
  logic          done;
  logic [RW-1:0] rows_done;
  logic          err;
  logic [2:0]    dbg_state;

  conv_out_wr_seq #(.TIMEOUT_CYC(100)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride),
    .cfg_row_len(cfg_row_len), .cfg_num_rows(cfg_num_rows),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .wr_go(wr_go), .wr_start_addr(wr_start_addr), .wr_size(wr_size),
    .wr_en(wr_en), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .busy(busy), .done(done), .rows_done(rows_done), .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int exp_size;

  // dram_wr model
  int dw_size, dw_cnt, dw_wait;
  bit dw_done_lvl, hold_done, rand_ready, rand_valid;

  // per-frame observations
  int cyc, go_cnt, beat_cnt, done_cnt, first_go_cyc, first_en_cyc, last_en_cyc, done_cyc;
  bit busy_at1;

  task automatic prep_frame(input int base, input int stride, input int len, input int rows,
                            input bit rr, input bit rv);
    logic [DW-1:0] v;
    src_q.delete(); exp_q.delete(); exp_addr_q.delete();
    for (int i = 0; i < len * rows; i++) begin
      v = DW'($urandom);
      src_q.push_back(v);
      exp_q.push_back(v);
    end
    if (len != 0) for (int r = 0; r < rows; r++) exp_addr_q.push_back(AW'(base + r * stride));
    exp_size = len;
    rand_ready = rr; rand_valid = rv;
    dw_size = 0; dw_cnt = 0; dw_wait = 0;
    cyc = 0; go_cnt = 0; beat_cnt = 0; done_cnt = 0;
    first_go_cyc = -1; first_en_cyc = -1; last_en_cyc = -1; done_cyc = -1; busy_at1 = 0;
    cfg_base_addr = AW'(base); cfg_stride = AW'(stride);
    cfg_row_len = SW'(len); cfg_num_rows = RW'(rows);
  endtask

  // One clock: drive at negedge, sample #1 later (what the next posedge sees).
  task automatic step(input bit start_val);
    logic [AW-1:0] ea;
    @(negedge clk);
    start = start_val;
    if (cyc > 0) begin
      cfg_base_addr = AW'($urandom); cfg_stride = AW'($urandom);
      cfg_row_len = SW'($urandom_range(0, 64)); cfg_num_rows = RW'($urandom_range(0, 9));
    end
    wr_ready = (dw_cnt < dw_size) ? (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
    wr_done = dw_done_lvl;
    s_valid = (src_q.size() > 0) ? (rand_valid ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
    s_data = s_valid ? src_q[0] : DW'($urandom);
    #1;
    if (wr_go) begin
      go_cnt++;
      if (first_go_cyc < 0) first_go_cyc = cyc;
      n_checks++;
      if (exp_addr_q.size() == 0) begin
        n_errors++; $display("FAIL go_unexpected: got wr_go at cycle %0d, required none", cyc);
      end else begin
        ea = exp_addr_q.pop_front();
        if (wr_start_addr !== ea) begin
          n_errors++; $display("FAIL go_addr: got %h required %h", wr_start_addr, ea);
        end
      end
      n_checks++;
      if (wr_size !== SW'(exp_size)) begin
        n_errors++; $display("FAIL go_size: got %0d required %0d", wr_size, exp_size);
      end
      dw_size = int'(wr_size); dw_cnt = 0; dw_done_lvl = 0; dw_wait = 0;
    end
    if (wr_en) begin
      beat_cnt++;
      if (first_en_cyc < 0) first_en_cyc = cyc;
      last_en_cyc = cyc;
      n_checks++;
      if (!wr_ready) begin
        n_errors++; $display("FAIL en_ready: wr_en=1 with wr_ready=%b, required wr_ready=1", wr_ready);
      end else if (exp_q.size() == 0) begin
        n_errors++; $display("FAIL data_extra: got %h required no element", wr_data);
      end else begin
        ea = '0;
        if (wr_data !== exp_q[0]) begin
          n_errors++; $display("FAIL data: got %h required %h", wr_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      dw_cnt++;
      if (dw_cnt == dw_size && !hold_done) dw_wait = $urandom_range(1, 4);
    end else if (dw_wait > 0) begin
      dw_wait--;
      if (dw_wait == 0) dw_done_lvl = 1;
    end
    if (s_valid && s_ready) void'(src_q.pop_front());
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (cyc == 1) busy_at1 = busy;
    cyc++;
  endtask

  task automatic run_frame(input int base, input int stride, input int len, input int rows,
                           input bit rr, input bit rv, input bit extra_start);
    int n_go, n_rows;
    prep_frame(base, stride, len, rows, rr, rv);
    n_go = (len != 0) ? rows : 0;
    n_rows = n_go;
    step(1'b1);
    while (done_cnt == 0 && cyc < 8000) step(extra_start && cyc == 6);
    for (int i = 0; i < 3; i++) step(1'b0);
    n_checks++;
    if (done_cnt != 1) begin
      n_errors++; $display("FAIL done_count: got %0d required 1 (len=%0d rows=%0d)", done_cnt, len, rows);
    end
    n_checks++;
    if (go_cnt != n_go) begin
      n_errors++; $display("FAIL go_count: got %0d required %0d", go_cnt, n_go);
    end
    n_checks++;
    if (beat_cnt != len * rows || exp_q.size() != 0) begin
      n_errors++; $display("FAIL beat_count: got %0d required %0d", beat_cnt, len * rows);
    end
    n_checks++;
    if (rows_done !== RW'(n_rows)) begin
      n_errors++; $display("FAIL rows_done: got %0d required %0d", rows_done, n_rows);
    end
    n_checks++;
    if (busy !== 1'b0 || busy_at1 !== 1'b1) begin
      n_errors++; $display("FAIL busy: got end=%b cycle1=%b required 0/1", busy, busy_at1);
    end
    n_checks++;
    if (err !== 1'b0) begin
      n_errors++; $display("FAIL err: got %b required 0", err);
    end
    if (n_go > 0) begin
      n_checks++;
      if (first_go_cyc != 1) begin
        n_errors++; $display("FAIL go_latency: got %0d required 1", first_go_cyc);
      end
      if (!rr && !rv) begin
        n_checks++;
        if (first_en_cyc != first_go_cyc + 2) begin
          n_errors++; $display("FAIL en_latency: got %0d required %0d", first_en_cyc, first_go_cyc + 2);
        end
      end
    end else begin
      n_checks++;
      if (done_cyc != 2) begin
        n_errors++; $display("FAIL empty_done_latency: got %0d required 2", done_cyc);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; s_valid = 0; s_data = '0; wr_ready = 0; wr_done = 0;
    cfg_base_addr = '0; cfg_stride = '0; cfg_row_len = '0; cfg_num_rows = '0;
    dw_done_lvl = 0; hold_done = 0;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({wr_go, wr_start_addr, wr_size, wr_en, wr_data, s_ready, busy, done, rows_done, err} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got go=%b addr=%h size=%0d busy=%b done=%b rows=%0d err=%b required all 0",
                           wr_go, wr_start_addr, wr_size, busy, done, rows_done, err);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({wr_go, busy, done, s_ready, wr_en} !== '0) begin
      n_errors++; $display("FAIL idle_outputs: got go=%b busy=%b done=%b s_ready=%b required 0", wr_go, busy, done, s_ready);
    end
  endtask

  task automatic test_three_rows();
    run_frame(32'h100, 8, 16, 3, 0, 0, 0);
  endtask

  task automatic test_odd_len();
    run_frame(32'h040, 3, 5, 1, 0, 0, 0);
  endtask

  task automatic test_random_ready();
    for (int k = 0; k < 5; k++)
      run_frame($urandom_range(0, 32767), $urandom_range(1, 40), $urandom_range(1, 40),
                $urandom_range(1, 5), 1, k[0], k == 2);
  endtask

  task automatic test_empty();
    run_frame(32'h300, 8, 16, 0, 0, 0, 0);
    run_frame(32'h300, 8, 0, 3, 0, 0, 0);
  endtask

  task automatic test_addr_wrap();
    run_frame(32'h7FF8, 32'h10, 7, 3, 1, 0, 0);
  endtask

  task automatic test_reset_mid();
    prep_frame(32'h200, 4, 8, 3, 0, 0);
    step(1'b1);
    while (!(go_cnt == 2 && beat_cnt >= 11) && cyc < 500) step(1'b0);
    n_checks++;
    if (go_cnt != 2) begin
      n_errors++; $display("FAIL reset_mid_reach: got %0d gos required 2", go_cnt);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({wr_go, wr_start_addr, wr_size, wr_en, wr_data, s_ready, busy, done, rows_done, err} !== '0) begin
      n_errors++; $display("FAIL reset_mid_outputs: got addr=%h size=%0d en=%b busy=%b rows=%0d required all 0",
                           wr_start_addr, wr_size, wr_en, busy, rows_done);
    end
    s_valid = 0; wr_ready = 0; wr_done = 0; dw_done_lvl = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_frame(32'h500, 6, 12, 2, 0, 0, 0);
  endtask

`ifdef CONV_WR_TIMEOUT_EN
  task automatic test_timeout();
    hold_done = 1;
    dw_done_lvl = 0;
    prep_frame(32'h010, 4, 4, 2, 0, 0);
    step(1'b1);
    while (done_cnt == 0 && cyc < 500) step(1'b0);
    n_checks++;
    if (done_cyc - last_en_cyc != 101 || err !== 1'b1 || rows_done !== '0 || go_cnt != 1) begin
      n_errors++; $display("FAIL timeout: got delay=%0d err=%b rows=%0d gos=%0d required 101/1/0/1",
                           done_cyc - last_en_cyc, err, rows_done, go_cnt);
    end
    hold_done = 0;
    run_frame(32'h020, 4, 4, 2, 0, 0, 0);
  endtask
`endif

  initial begin
    test_reset();
    test_three_rows();
    test_odd_len();
    test_random_ready();
    test_empty();
    test_addr_wrap();
    test_reset_mid();
`ifdef CONV_WR_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
